// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES receive loader and its byte shifter.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    KEY_ARM  = 2'd1,
    KEY_WAIT = 2'd2,
    BLK_OUT  = 2'd3
  } rx_state_t;
endpackage

// File: rtl/rx_byte_shifter.sv
// Byte-to-frame assembler: shift register, byte count, latched frame type,
// type-mismatch detection and a combinational frame-complete strobe.
module rx_byte_shifter
  import aes_pkg::*;
#(
  parameter int FRAME_BYTES = AES_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_accept,
  input  logic [7:0] i_byte,
  input  logic       i_is_key,
  input  logic       i_clear,
  output aes_block_t o_frame,
  output logic       o_done,
  output logic       o_mismatch,
  output logic       o_busy
);
  localparam int CW = $clog2(FRAME_BYTES + 1);

  aes_block_t    r_sr;
  logic [CW-1:0] r_cnt;
  logic          r_type;
  logic          w_first;
  logic [CW-1:0] w_cnt_next;

  // A mismatching byte restarts the frame as its first byte.
  always_comb begin
    o_mismatch = i_accept && (r_cnt != CW'(0)) && (i_is_key != r_type);
    w_first    = (r_cnt == CW'(0)) || o_mismatch;
    if (w_first) begin
      w_cnt_next = CW'(1);
    end else begin
      w_cnt_next = r_cnt + CW'(1);
    end
    o_done  = i_accept && (w_cnt_next == CW'(FRAME_BYTES));
    o_frame = {r_sr[AES_BLOCK_W-9:0], i_byte};
    o_busy  = (r_cnt != CW'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr   <= '0;
      r_cnt  <= CW'(0);
      r_type <= 1'b0;
    end else if (i_accept) begin
      r_sr <= o_frame;
      if (w_first) begin
        r_type <= i_is_key;
      end
      r_cnt <= o_done ? CW'(0) : w_cnt_next;
    end else if (i_clear) begin
      r_cnt <= CW'(0);
    end
  end
endmodule

// File: rtl/aes_rx_loader.sv
// Assembles a byte stream into AES key/data frames, hands keys to the key
// generator (chg_key/change_key_done) and data blocks downstream (valid/ready).
module aes_rx_loader
  import aes_pkg::*;
#(
  parameter int FRAME_BYTES = AES_BYTES,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_is_key,
  output logic       rx_ready,
  output aes_block_t rx_key,
  output logic       chg_key,
  input  logic       change_key_done,
  output aes_block_t blk_data,
  output logic       blk_valid,
  input  logic       blk_ready,
  output logic       key_loaded,
  output logic       frame_err
);
  localparam int GW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic [GW-1:0] r_gap;
  logic          r_rx_ready;
  aes_block_t    r_rx_key;
  logic          r_chg_key;
  aes_block_t    r_blk_data;
  logic          r_blk_valid;
  logic          r_key_loaded;
  logic          r_frame_err;

  logic          w_accept;
  logic          w_timeout;
  logic          w_drop;
  logic          w_done;
  logic          w_mismatch;
  logic          w_busy;
  aes_block_t    w_frame;

  assign w_accept = rx_valid && r_rx_ready;

  rx_byte_shifter #(
    .FRAME_BYTES(FRAME_BYTES)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .i_accept  (w_accept),
    .i_byte    (rx_data),
    .i_is_key  (rx_is_key),
    .i_clear   (w_timeout),
    .o_frame   (w_frame),
    .o_done    (w_done),
    .o_mismatch(w_mismatch),
    .o_busy    (w_busy)
  );

  always_comb begin
    w_timeout = (TIMEOUT != 0) && (r_state == COLLECT) && w_busy && !w_accept
                && (r_gap == GW'(TO_LAST));
    w_drop    = w_done && !rx_is_key && !r_key_loaded;
  end

  // KEY_ARM waits for done low first so a stale done from the last key is ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: begin
        if (w_done && rx_is_key) begin
          w_state_next = KEY_ARM;
        end else if (w_done && r_key_loaded) begin
          w_state_next = BLK_OUT;
        end else begin
          w_state_next = COLLECT;
        end
      end
      KEY_ARM: begin
        if (!change_key_done) begin
          w_state_next = KEY_WAIT;
        end else begin
          w_state_next = KEY_ARM;
        end
      end
      KEY_WAIT: begin
        if (change_key_done) begin
          w_state_next = COLLECT;
        end else begin
          w_state_next = KEY_WAIT;
        end
      end
      BLK_OUT: begin
        if (blk_ready) begin
          w_state_next = COLLECT;
        end else begin
          w_state_next = BLK_OUT;
        end
      end
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap <= GW'(0);
    end else if ((TIMEOUT == 0) || (r_state != COLLECT) || !w_busy || w_accept || w_timeout) begin
      r_gap <= GW'(0);
    end else begin
      r_gap <= r_gap + GW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= COLLECT;
      r_rx_ready   <= 1'b0;
      r_rx_key     <= '0;
      r_chg_key    <= 1'b0;
      r_blk_data   <= '0;
      r_blk_valid  <= 1'b0;
      r_key_loaded <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rx_ready  <= (w_state_next == COLLECT);
      r_frame_err <= w_mismatch || w_timeout || w_drop;
      if ((r_state == COLLECT) && w_done && rx_is_key) begin
        r_rx_key     <= w_frame;
        r_chg_key    <= 1'b1;
        r_key_loaded <= 1'b0;
      end else if ((r_state == KEY_WAIT) && change_key_done) begin
        r_chg_key    <= 1'b0;
        r_key_loaded <= 1'b1;
      end
      if ((r_state == COLLECT) && w_done && !rx_is_key && r_key_loaded) begin
        r_blk_data  <= w_frame;
        r_blk_valid <= 1'b1;
      end else if ((r_state == BLK_OUT) && blk_ready) begin
        r_blk_valid <= 1'b0;
      end
    end
  end

  assign rx_ready   = r_rx_ready;
  assign rx_key     = r_rx_key;
  assign chg_key    = r_chg_key;
  assign blk_data   = r_blk_data;
  assign blk_valid  = r_blk_valid;
  assign key_loaded = r_key_loaded;
  assign frame_err  = r_frame_err;
endmodule
